// File: rtl/video_timing_pkg.sv
// Shared raster types, the NinjaKun default geometry and the modular helpers
// used to place the (possibly shifted) sync windows.
package video_timing_pkg;

    localparam int CNT_W = 9;

    typedef struct packed {
        int h_total;
        int h_act_start;
        int h_act_end;
        int hs_start;
        int hs_end;
        int v_total;
        int v_act_start;
        int v_act_end;
        int vs_start;
        int vs_end;
    } timing_t;

    localparam timing_t NINJAKUN_TIMING = '{
        h_total:     384,
        h_act_start: 16,
        h_act_end:   272,
        hs_start:    312,
        hs_end:      343,
        v_total:     263,
        v_act_start: 16,
        v_act_end:   208,
        vs_start:    236,
        vs_end:      243
    };

    // Control bits travelling alongside the pixel data; syncs are active low.
    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync_n;
        logic vsync_n;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{hblank: 1'b1, vblank: 1'b1, hsync_n: 1'b1, vsync_n: 1'b1};

    // value + adj folded back into 0..total-1; |adj| is always below total.
    function automatic logic [CNT_W-1:0] wrap_add(input int value,
                                                  input logic signed [3:0] adj,
                                                  input int total);
        int sum;
        sum = value + int'(adj);
        if (sum < 0) begin
            sum = sum + total;
        end else if (sum >= total) begin
            sum = sum - total;
        end
        return CNT_W'(sum);
    endfunction

    // Half-open window [lo, hi); lo > hi means the window straddles the wrap.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        if (lo <= hi) begin
            return (cnt >= lo) && (cnt < hi);
        end
        return (cnt >= lo) || (cnt < hi);
    endfunction

endpackage

// File: rtl/video_timing_dly.sv
// Pixel-enable qualified delay line carrying blank/sync flags together with
// the core's RGB, so video and its framing stay aligned at any depth.
module video_timing_dly
    import video_timing_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CW    = 12
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          ce,
    input  ctl_t          ctl_in,
    input  logic [CW-1:0] rgb_in,
    output ctl_t          ctl_out,
    output logic [CW-1:0] rgb_out
);

    ctl_t          ctl_pipe [DEPTH];
    logic [CW-1:0] rgb_pipe [DEPTH];

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctl_pipe[i] <= CTL_IDLE;
                rgb_pipe[i] <= '0;
            end
        end else if (ce) begin
            ctl_pipe[0] <= ctl_in;
            rgb_pipe[0] <= rgb_in;
            for (int i = 1; i < DEPTH; i++) begin
                ctl_pipe[i] <= ctl_pipe[i-1];
                rgb_pipe[i] <= rgb_pipe[i-1];
            end
        end
    end

    assign ctl_out = ctl_pipe[DEPTH-1];
    assign rgb_out = rgb_pipe[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, visible-origin
// coordinates with frame-synchronous flip, shiftable syncs and gated RGB.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL     = NINJAKUN_TIMING.h_total,
    parameter int H_ACT_START = NINJAKUN_TIMING.h_act_start,
    parameter int H_ACT_END   = NINJAKUN_TIMING.h_act_end,
    parameter int HS_START    = NINJAKUN_TIMING.hs_start,
    parameter int HS_END      = NINJAKUN_TIMING.hs_end,
    parameter int V_TOTAL     = NINJAKUN_TIMING.v_total,
    parameter int V_ACT_START = NINJAKUN_TIMING.v_act_start,
    parameter int V_ACT_END   = NINJAKUN_TIMING.v_act_end,
    parameter int VS_START    = NINJAKUN_TIMING.vs_start,
    parameter int VS_END      = NINJAKUN_TIMING.vs_end,
    parameter int CW          = 12,
    parameter int RGB_DLY     = 1
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic              PCE,
    input  logic              FLIP,
    input  logic signed [3:0] H_ADJ,
    input  logic signed [3:0] V_ADJ,
    input  logic [CW-1:0]     iRGB,
    output logic [CNT_W-1:0]  HPOS,
    output logic [CNT_W-1:0]  VPOS,
    output logic [CW-1:0]     oRGB,
    output logic              HBLK,
    output logic              VBLK,
    output logic              HSYN,
    output logic              VSYN,
    output logic              LINE_ST,
    output logic              FRAME_ST
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_A0     = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] H_A1     = CNT_W'(H_ACT_END);
    localparam logic [CNT_W-1:0] V_A0     = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_A1     = CNT_W'(V_ACT_END);
    localparam logic [CNT_W-1:0] H_WIDTH  = CNT_W'(H_ACT_END - H_ACT_START);
    localparam logic [CNT_W-1:0] V_HEIGHT = CNT_W'(V_ACT_END - V_ACT_START);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             flip_q;
    logic signed [3:0] hadj_q;
    logic signed [3:0] vadj_q;
    logic             line_st_q;
    logic             frame_st_q;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    // Frame-level controls are captured only on the step into (0,0) so a
    // mid-frame change never tears the picture.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            hcnt       <= '0;
            vcnt       <= '0;
            flip_q     <= 1'b0;
            hadj_q     <= '0;
            vadj_q     <= '0;
            line_st_q  <= 1'b0;
            frame_st_q <= 1'b0;
        end else begin
            line_st_q  <= 1'b0;
            frame_st_q <= 1'b0;
            if (PCE) begin
                if (h_wrap) begin
                    hcnt      <= '0;
                    line_st_q <= 1'b1;
                    if (v_wrap) begin
                        vcnt       <= '0;
                        frame_st_q <= 1'b1;
                        flip_q     <= FLIP;
                        hadj_q     <= H_ADJ;
                        vadj_q     <= V_ADJ;
                    end else begin
                        vcnt <= vcnt + CNT_W'(1);
                    end
                end else begin
                    hcnt <= hcnt + CNT_W'(1);
                end
            end
        end
    end

    // Coordinates relative to the visible origin, mod 512, mirrored on flip.
    logic [CNT_W-1:0] hrel;
    logic [CNT_W-1:0] vrel;

    always_comb begin
        hrel = hcnt - H_A0;
        vrel = vcnt - V_A0;
        HPOS = flip_q ? (H_WIDTH - CNT_W'(1) - hrel) : hrel;
        VPOS = flip_q ? (V_HEIGHT - CNT_W'(1) - vrel) : vrel;
    end

    logic [CNT_W-1:0] hs_lo;
    logic [CNT_W-1:0] hs_hi;
    logic [CNT_W-1:0] vs_lo;
    logic [CNT_W-1:0] vs_hi;

    assign hs_lo = wrap_add(HS_START, hadj_q, H_TOTAL);
    assign hs_hi = wrap_add(HS_END,   hadj_q, H_TOTAL);
    assign vs_lo = wrap_add(VS_START, vadj_q, V_TOTAL);
    assign vs_hi = wrap_add(VS_END,   vadj_q, V_TOTAL);

    ctl_t raw_ctl;

    always_comb begin
        raw_ctl         = CTL_IDLE;
        raw_ctl.hblank  = !((hcnt >= H_A0) && (hcnt < H_A1));
        raw_ctl.vblank  = !((vcnt >= V_A0) && (vcnt < V_A1));
        raw_ctl.hsync_n = !in_window(hcnt, hs_lo, hs_hi);
        raw_ctl.vsync_n = !in_window(vcnt, vs_lo, vs_hi);
    end

    ctl_t          out_ctl;
    logic [CW-1:0] out_rgb;

    video_timing_dly #(
        .DEPTH (RGB_DLY),
        .CW    (CW)
    ) u_dly (
        .clk_sys (MCLK),
        .rst_n   (RESET_N),
        .ce      (PCE),
        .ctl_in  (raw_ctl),
        .rgb_in  (iRGB),
        .ctl_out (out_ctl),
        .rgb_out (out_rgb)
    );

    assign HBLK     = out_ctl.hblank;
    assign VBLK     = out_ctl.vblank;
    assign HSYN     = out_ctl.hsync_n;
    assign VSYN     = out_ctl.vsync_n;
    assign oRGB     = (out_ctl.hblank || out_ctl.vblank) ? '0 : out_rgb;
    assign LINE_ST  = line_st_q;
    assign FRAME_ST = frame_st_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: four geometries of video_timing_gen on one master clock,
// expectations hand-derived from the raster parameters of each instance.
module tb_video_timing_gen;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic [3:0]  rst_n = 4'b0000;
    logic        pce   = 1'b1;
    logic        flip  = 1'b0;
    logic [3:0]  h_adj = 4'b0000;
    logic [3:0]  v_adj = 4'b0000;
    logic [11:0] irgb  = 12'h000;

    logic [8:0]  hpos [4];
    logic [8:0]  vpos [4];
    logic [11:0] orgb [4];
    logic        hblk [4];
    logic        vblk [4];
    logic        hsyn [4];
    logic        vsyn [4];
    logic        line_st [4];
    logic        frame_st [4];

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int ht    = 384;
    int vt    = 263;
    int h     = 0;
    int v     = 0;

    // 0: default geometry
    video_timing_gen u_a (
        .MCLK(mclk), .RESET_N(rst_n[0]), .PCE(pce), .FLIP(flip), .H_ADJ(h_adj), .V_ADJ(v_adj),
        .iRGB(irgb), .HPOS(hpos[0]), .VPOS(vpos[0]), .oRGB(orgb[0]), .HBLK(hblk[0]), .VBLK(vblk[0]),
        .HSYN(hsyn[0]), .VSYN(vsyn[0]), .LINE_ST(line_st[0]), .FRAME_ST(frame_st[0])
    );

    // 1: default lines, 8-line frame
    video_timing_gen #(
        .V_TOTAL(8), .V_ACT_START(1), .V_ACT_END(6), .VS_START(6), .VS_END(7)
    ) u_b (
        .MCLK(mclk), .RESET_N(rst_n[1]), .PCE(pce), .FLIP(flip), .H_ADJ(h_adj), .V_ADJ(v_adj),
        .iRGB(irgb), .HPOS(hpos[1]), .VPOS(vpos[1]), .oRGB(orgb[1]), .HBLK(hblk[1]), .VBLK(vblk[1]),
        .HSYN(hsyn[1]), .VSYN(vsyn[1]), .LINE_ST(line_st[1]), .FRAME_ST(frame_st[1])
    );

    // 2: 16-pixel lines, default vertical, three-stage pipeline
    video_timing_gen #(
        .H_TOTAL(16), .H_ACT_START(2), .H_ACT_END(10), .HS_START(12), .HS_END(14), .RGB_DLY(3)
    ) u_c (
        .MCLK(mclk), .RESET_N(rst_n[2]), .PCE(pce), .FLIP(flip), .H_ADJ(h_adj), .V_ADJ(v_adj),
        .iRGB(irgb), .HPOS(hpos[2]), .VPOS(vpos[2]), .oRGB(orgb[2]), .HBLK(hblk[2]), .VBLK(vblk[2]),
        .HSYN(hsyn[2]), .VSYN(vsyn[2]), .LINE_ST(line_st[2]), .FRAME_ST(frame_st[2])
    );

    // 3: sync at the end of the line, 4-line frame
    video_timing_gen #(
        .HS_START(380), .HS_END(383), .V_TOTAL(4), .V_ACT_START(1), .V_ACT_END(3),
        .VS_START(3), .VS_END(4)
    ) u_d (
        .MCLK(mclk), .RESET_N(rst_n[3]), .PCE(pce), .FLIP(flip), .H_ADJ(h_adj), .V_ADJ(v_adj),
        .iRGB(irgb), .HPOS(hpos[3]), .VPOS(vpos[3]), .oRGB(orgb[3]), .HBLK(hblk[3]), .VBLK(vblk[3]),
        .HSYN(hsyn[3]), .VSYN(vsyn[3]), .LINE_ST(line_st[3]), .FRAME_ST(frame_st[3])
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One PCE pixel step; the bench's own (h,v) follows the raster geometry.
    task automatic adv1();
        @(negedge mclk);
        if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end else begin
            h++;
        end
        irgb = 12'(32'h100 + h);
    endtask

    task automatic goto_pos(input int th, input int tv);
        while (!(h == th && v == tv)) adv1();
    endtask

    task automatic hold_reset(input int s);
        sel = s;
        case (s)
            0: begin ht = 384; vt = 263; end
            1: begin ht = 384; vt = 8;   end
            2: begin ht = 16;  vt = 263; end
            default: begin ht = 384; vt = 4; end
        endcase
        @(negedge mclk);
        pce = 1'b1;
        rst_n[s] = 1'b0;
        repeat (2) @(negedge mclk);
    endtask

    task automatic release_reset();
        rst_n[sel] = 1'b1;
        h = 0;
        v = 0;
        irgb = 12'h100;
    endtask

    // Runs one full line from h=0; indices are pixel steps 1..ht.
    task automatic measure_line(output int hs_first, output int hs_cnt, output int hb_fall,
                                output int hb_rise, output int ls_cnt);
        hs_first = -1; hs_cnt = 0; hb_fall = -1; hb_rise = -1; ls_cnt = 0;
        for (int k = 1; k <= ht; k++) begin
            adv1();
            if (!hsyn[sel]) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (!hblk[sel] && hb_fall < 0) hb_fall = k;
            if (hblk[sel] && hb_fall >= 0 && hb_rise < 0) hb_rise = k;
            if (line_st[sel]) ls_cnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        int hs_first, hs_cnt, hb_fall, hb_rise, ls_cnt;
        int changes, ls_idx, fs_cnt, n, vact, vs_cnt, vs_first;
        logic [8:0] prev;

        // ---------------- instance A: default geometry ----------------
        hold_reset(0);
        check("rst_hpos", hpos[0], 496);
        check("rst_vpos", vpos[0], 496);
        check("rst_hblk", hblk[0], 1);
        check("rst_vblk", vblk[0], 1);
        check("rst_hsyn", hsyn[0], 1);
        check("rst_vsyn", vsyn[0], 1);
        check("rst_orgb", orgb[0], 0);
        check("rst_line_st", line_st[0], 0);
        check("rst_frame_st", frame_st[0], 0);
        release_reset();

        measure_line(hs_first, hs_cnt, hb_fall, hb_rise, ls_cnt);
        check("a_hblk_fall", hb_fall, 17);
        check("a_hblk_rise", hb_rise, 273);
        check("a_visible", hb_rise - hb_fall, 256);
        check("a_hsyn_first", hs_first, 313);
        check("a_hsyn_width", hs_cnt, 31);
        check("a_line_st_cnt", ls_cnt, 1);
        check("a_no_frame_st", frame_st[0], 0);
        check("a_vpos_line1", vpos[0], 497);

        goto_pos(100, 16);
        check("a_act_hpos", hpos[0], 84);
        check("a_act_vpos", vpos[0], 0);
        check("a_act_vblk", vblk[0], 0);
        check("a_act_hblk", hblk[0], 0);
        check("a_act_orgb", orgb[0], 355);

        goto_pos(150, 50);
        check("a_pre_rst_hpos", hpos[0], 134);
        check("a_pre_rst_vpos", vpos[0], 34);
        rst_n[0] = 1'b0;
        @(negedge mclk);
        check("a_midrst_hpos", hpos[0], 496);
        check("a_midrst_vpos", vpos[0], 496);
        check("a_midrst_hblk", hblk[0], 1);
        check("a_midrst_vblk", vblk[0], 1);
        check("a_midrst_hsyn", hsyn[0], 1);
        check("a_midrst_orgb", orgb[0], 0);

        // PCE on every 8th MCLK: one line spans 384*8 clocks
        rst_n[0] = 1'b1;
        prev = hpos[0];
        changes = 0; ls_cnt = 0; ls_idx = -1; fs_cnt = 0;
        for (int i = 0; i < 384 * 8; i++) begin
            pce = (i % 8 == 0);
            @(negedge mclk);
            if (hpos[0] != prev) changes++;
            prev = hpos[0];
            if (line_st[0]) begin
                ls_cnt++;
                ls_idx = i;
            end
            if (frame_st[0]) fs_cnt++;
        end
        pce = 1'b1;
        check("slow_hpos_steps", changes, 384);
        check("slow_line_st_cnt", ls_cnt, 1);
        check("slow_line_st_at", ls_idx, 3064);
        check("slow_frame_st", fs_cnt, 0);
        check("slow_end_hpos", hpos[0], 496);

        // ---------------- instance B: H_ADJ -8, flip, reset restart ----------------
        h_adj = 4'b1000;
        hold_reset(1);
        release_reset();
        measure_line(hs_first, hs_cnt, hb_fall, hb_rise, ls_cnt);
        check("b_f0_hsyn_first", hs_first, 313);
        check("b_f0_hsyn_width", hs_cnt, 31);
        goto_pos(0, 0);
        check("b_frame_st", frame_st[1], 1);
        check("b_frame_line_st", line_st[1], 1);
        adv1();
        check("b_frame_st_width", frame_st[1], 0);
        goto_pos(0, 1);
        measure_line(hs_first, hs_cnt, hb_fall, hb_rise, ls_cnt);
        check("b_adj_hsyn_first", hs_first, 305);
        check("b_adj_hsyn_width", hs_cnt, 31);

        goto_pos(0, 3);
        flip = 1'b1;
        goto_pos(16, 4);
        check("b_midflip_hpos", hpos[1], 0);
        check("b_midflip_vpos", vpos[1], 3);
        goto_pos(0, 0);
        check("b_flip_frame_st", frame_st[1], 1);
        check("b_flip_h0_hpos", hpos[1], 271);
        check("b_flip_v0_vpos", vpos[1], 5);
        goto_pos(16, 1);
        check("b_flip_first_hpos", hpos[1], 255);
        check("b_flip_first_vpos", vpos[1], 4);
        goto_pos(271, 1);
        check("b_flip_last_hpos", hpos[1], 0);
        goto_pos(16, 5);
        check("b_flip_last_vpos", vpos[1], 0);

        goto_pos(150, 3);
        rst_n[1] = 1'b0;
        @(negedge mclk);
        check("b_rst_hpos", hpos[1], 496);
        check("b_rst_vpos", vpos[1], 511);
        check("b_rst_hblk", hblk[1], 1);
        check("b_rst_frame_st", frame_st[1], 0);
        release_reset();
        adv1();
        check("b_rst_unflipped", hpos[1], 497);
        n = 1;
        while (!frame_st[1] && n < 4000) begin
            adv1();
            n++;
        end
        check("b_rst_to_frame_st", n, 3072);
        check("b_reflip_hpos", hpos[1], 271);
        flip = 1'b0;
        h_adj = 4'b0000;

        // ---------------- instance C: vertical counts, 3-stage pipeline ----------------
        hold_reset(2);
        release_reset();
        vact = 0; vs_cnt = 0; vs_first = -1; fs_cnt = 0; n = -1;
        for (int k = 1; k <= 16 * 263; k++) begin
            adv1();
            if (h == 7) begin
                if (!vblk[2]) vact++;
                if (!vsyn[2]) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = v;
                end
            end
            if (frame_st[2]) begin
                fs_cnt++;
                n = k;
            end
        end
        check("c_active_lines", vact, 192);
        check("c_vsyn_lines", vs_cnt, 7);
        check("c_vsyn_first", vs_first, 236);
        check("c_frame_st_cnt", fs_cnt, 1);
        check("c_frame_len", n, 4208);

        goto_pos(4, 20);
        check("c_pre_hblk", hblk[2], 1);
        check("c_pre_orgb", orgb[2], 0);
        adv1();
        check("c_first_hblk", hblk[2], 0);
        check("c_first_orgb", orgb[2], 258);
        check("c_first_hpos", hpos[2], 3);
        goto_pos(12, 20);
        check("c_last_orgb", orgb[2], 265);
        check("c_last_hsyn", hsyn[2], 1);
        adv1();
        check("c_end_hblk", hblk[2], 1);
        check("c_end_orgb", orgb[2], 0);
        goto_pos(15, 20);
        check("c_tail_orgb", orgb[2], 0);
        check("c_tail_hsyn", hsyn[2], 0);

        // ---------------- instance D: H_ADJ +7 wraps the sync window ----------------
        h_adj = 4'b0111;
        hold_reset(3);
        release_reset();
        measure_line(hs_first, hs_cnt, hb_fall, hb_rise, ls_cnt);
        check("d_f0_hsyn_first", hs_first, 381);
        check("d_f0_hsyn_width", hs_cnt, 3);
        goto_pos(0, 0);
        check("d_frame_st", frame_st[3], 1);
        measure_line(hs_first, hs_cnt, hb_fall, hb_rise, ls_cnt);
        check("d_wrap_hsyn_first", hs_first, 4);
        check("d_wrap_hsyn_width", hs_cnt, 3);
        check("d_wrap_line_st", ls_cnt, 1);
        h_adj = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
